ped_request_ctrl: RTL and testbench



---
 rtl/ped_request_ctrl.sv | 153 +++++++++++++++
 tb/tb_ped_request_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ped_request_ctrl.sv
// Pedestrian request scheduler: synchronises and debounces the button inputs, holds one merged
// request to the light controller, and tracks the walk phase, holdoff, timeout and crossing count.
//
// state   | meaning
// IDLE    | no request forwarded; waiting for a latched press or a walk phase
// REQUEST | req_out held high; waiting for ped_green or the request timeout
// SERVING | walk phase in progress; pending presses are being served
// HOLD    | post-walk holdoff; presses are latched but not forwarded
module ped_request_ctrl #(
    parameter int TP         = 1,
    parameter int N_BTN      = 2,
    parameter int DEB_CYCLES = 3,
    parameter int HOLDOFF    = 10,
    parameter int REQ_TMO    = 120
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    input  logic             ped_green,
    output logic             req_out,
    output logic [N_BTN-1:0] wait_led,
    output logic             req_err,
    output logic [7:0]       cross_cnt,
    output logic [1:0]       state_dbg
);

    if (N_BTN < 1 || N_BTN > 8 || DEB_CYCLES < 1 || DEB_CYCLES > 15 ||
        HOLDOFF < 1 || HOLDOFF > 255 || REQ_TMO < 1 || REQ_TMO > 255 || TP < 0) begin : g_bad_param
        $error("ped_request_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQUEST = 2'b01,
        SERVING = 2'b10,
        HOLD    = 2'b11
    } state_t;

    localparam logic [4:0] DEB_LAST  = 5'(DEB_CYCLES);
    localparam logic [7:0] TMO_LAST  = 8'(REQ_TMO - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF - 1);

    state_t           state, state_next;
    logic [N_BTN-1:0] s1, s2;
    logic [N_BTN-1:0] deb, deb_next;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] pending, pending_next;
    logic [3:0]       deb_cnt      [N_BTN];
    logic [3:0]       deb_cnt_next [N_BTN];
    logic [7:0]       tmo, tmo_next;
    logic [7:0]       hold_cnt, hold_cnt_next;
    logic             err_set;
    logic             served;

    // A press is the debounced 0->1 edge; releases only flip the level.
    always_comb begin
        deb_next = deb;
        press    = '0;
        for (int i = 0; i < N_BTN; i++) begin
            deb_cnt_next[i] = 4'd0;
            if (s2[i] != deb[i]) begin
                if ({1'b0, deb_cnt[i]} + 5'd1 == DEB_LAST) begin
                    deb_next[i] = ~deb[i];
                    press[i]    = ~deb[i];
                end else begin
                    deb_cnt_next[i] = deb_cnt[i] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        state_next    = state;
        tmo_next      = 8'd0;
        hold_cnt_next = 8'd0;
        err_set       = 1'b0;
        served        = 1'b0;
        case (state)
            IDLE: begin
                if (ped_green)
                    state_next = SERVING;
                else if (|pending)
                    state_next = REQUEST;
            end
            REQUEST: begin
                if (ped_green) begin
                    state_next = SERVING;
                end else if (tmo == TMO_LAST) begin
                    state_next = IDLE;
                    err_set    = 1'b1;
                end else begin
                    tmo_next = tmo + 8'd1;
                end
            end
            SERVING: begin
                if (!ped_green) begin
                    state_next = HOLD;
                    served     = 1'b1;
                end
            end
            HOLD: begin
                if (ped_green)
                    state_next = SERVING;
                else if (hold_cnt == HOLD_LAST)
                    state_next = IDLE;
                else
                    hold_cnt_next = hold_cnt + 8'd1;
            end
            default: state_next = IDLE;
        endcase
        // Clearing beats a coincident press while entering or sitting in SERVING.
        if (state == SERVING || state_next == SERVING)
            pending_next = '0;
        else
            pending_next = pending | press;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            s1        <= '0;
            s2        <= '0;
            deb       <= '0;
            pending   <= '0;
            tmo       <= 8'd0;
            hold_cnt  <= 8'd0;
            req_out   <= 1'b0;
            req_err   <= 1'b0;
            cross_cnt <= 8'd0;
            for (int i = 0; i < N_BTN; i++)
                deb_cnt[i] <= 4'd0;
        end else begin
            state    <= state_next;
            s1       <= btn_in;
            s2       <= s1;
            deb      <= deb_next;
            pending  <= pending_next;
            tmo      <= tmo_next;
            hold_cnt <= hold_cnt_next;
            req_out  <= (state_next == REQUEST);
            for (int i = 0; i < N_BTN; i++)
                deb_cnt[i] <= deb_cnt_next[i];
            if (err_set)
                req_err <= 1'b1;
            if (served && cross_cnt != 8'hFF)
                cross_cnt <= cross_cnt + 8'd1;
        end
    end

    assign wait_led  = pending;
    assign state_dbg = state;

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Directed bench for ped_request_ctrl: expected outputs are queued when stimulus is driven
// and popped against the DUT after the corresponding clock edges.
module tb_ped_request_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] btn_in;
    logic       ped_green;
    logic       req_out;
    logic [1:0] wait_led;
    logic       req_err;
    logic [7:0] cross_cnt;
    logic [1:0] state_dbg;

    ped_request_ctrl #(
        .TP(1), .N_BTN(2), .DEB_CYCLES(3), .HOLDOFF(10), .REQ_TMO(120)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .ped_green(ped_green),
        .req_out(req_out), .wait_led(wait_led), .req_err(req_err),
        .cross_cnt(cross_cnt), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    logic [7:0] exp_cnt;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input string tag, input logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [7:0] obs);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL sb_underflow: observed %0h with no expected entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                miscompares++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic exp_out(input string tag, input logic r, input logic [1:0] w,
                           input logic e, input logic [7:0] c, input logic [1:0] s);
        push_exp({tag, "_req_out"}, {7'd0, r});
        push_exp({tag, "_wait_led"}, {6'd0, w});
        push_exp({tag, "_req_err"}, {7'd0, e});
        push_exp({tag, "_cross_cnt"}, c);
        push_exp({tag, "_state"}, {6'd0, s});
    endtask

    task automatic pop_out();
        pop_chk({7'd0, req_out});
        pop_chk({6'd0, wait_led});
        pop_chk({7'd0, req_err});
        pop_chk(cross_cnt);
        pop_chk({6'd0, state_dbg});
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
        int n = 0;
        while (state_dbg !== s && n < budget) begin
            tick(1);
            n++;
        end
        push_exp(tag, {6'd0, s});
        pop_chk({6'd0, state_dbg});
    endtask

    initial begin
        rst       = 1'b1;
        btn_in    = 2'b00;
        ped_green = 1'b0;

        // reset state
        exp_out("reset", 1'b0, 2'b00, 1'b0, 8'd0, 2'b00);
        tick(3);
        pop_out();

        // 1: held press on button 0, pending at edge 5, request at edge 6
        rst    = 1'b0;
        btn_in = 2'b01;
        exp_out("t1_e4", 1'b0, 2'b00, 1'b0, 8'd0, 2'b00);
        tick(4);
        pop_out();
        exp_out("t1_e5", 1'b0, 2'b01, 1'b0, 8'd0, 2'b00);
        tick(1);
        pop_out();
        exp_out("t1_e6", 1'b1, 2'b01, 1'b0, 8'd0, 2'b01);
        tick(1);
        pop_out();
        btn_in = 2'b00;

        // 2: a 2-cycle glitch on button 1 never latches
        btn_in = 2'b10;
        tick(2);
        btn_in = 2'b00;
        exp_out("t2_glitch", 1'b1, 2'b01, 1'b0, 8'd0, 2'b01);
        tick(6);
        pop_out();

        // 3: serve the request, then a 10-cycle holdoff
        ped_green = 1'b1;
        exp_out("t3_serve", 1'b0, 2'b00, 1'b0, 8'd0, 2'b10);
        tick(1);
        pop_out();
        exp_out("t3_walk", 1'b0, 2'b00, 1'b0, 8'd0, 2'b10);
        tick(29);
        pop_out();
        ped_green = 1'b0;
        exp_out("t3_hold", 1'b0, 2'b00, 1'b0, 8'd1, 2'b11);
        tick(1);
        pop_out();
        exp_out("t3_hold9", 1'b0, 2'b00, 1'b0, 8'd1, 2'b11);
        tick(9);
        pop_out();
        exp_out("t3_idle", 1'b0, 2'b00, 1'b0, 8'd1, 2'b00);
        tick(1);
        pop_out();
        exp_out("t3_stay", 1'b0, 2'b00, 1'b0, 8'd1, 2'b00);
        tick(2);
        pop_out();

        // 4: press during holdoff is latched but only forwarded after HOLD
        ped_green = 1'b1;
        exp_out("t4_serve", 1'b0, 2'b00, 1'b0, 8'd1, 2'b10);
        tick(1);
        pop_out();
        ped_green = 1'b0;
        exp_out("t4_hold", 1'b0, 2'b00, 1'b0, 8'd2, 2'b11);
        tick(1);
        pop_out();
        btn_in = 2'b01;
        exp_out("t4_h4", 1'b0, 2'b00, 1'b0, 8'd2, 2'b11);
        tick(4);
        pop_out();
        exp_out("t4_h5", 1'b0, 2'b01, 1'b0, 8'd2, 2'b11);
        tick(1);
        pop_out();
        exp_out("t4_idle", 1'b0, 2'b01, 1'b0, 8'd2, 2'b00);
        tick(5);
        pop_out();
        exp_out("t4_req", 1'b1, 2'b01, 1'b0, 8'd2, 2'b01);
        tick(1);
        pop_out();
        btn_in = 2'b00;

        // 5: request timeout after 120 REQUEST cycles, then re-request
        exp_out("t5_r119", 1'b1, 2'b01, 1'b0, 8'd2, 2'b01);
        tick(119);
        pop_out();
        exp_out("t5_tmo", 1'b0, 2'b01, 1'b1, 8'd2, 2'b00);
        tick(1);
        pop_out();
        exp_out("t5_rereq", 1'b1, 2'b01, 1'b1, 8'd2, 2'b01);
        tick(1);
        pop_out();

        // 6: 260 walk phases saturate the crossing counter
        exp_cnt = 8'd2;
        for (int i = 0; i < 260; i++) begin
            ped_green = 1'b1;
            tick(1);
            ped_green = 1'b0;
            if (exp_cnt != 8'hFF)
                exp_cnt = exp_cnt + 8'd1;
            push_exp("t6_cnt", exp_cnt);
            tick(1);
            pop_chk(cross_cnt);
            tick(10);
        end
        exp_out("t6_sat", 1'b0, 2'b00, 1'b1, 8'd255, 2'b00);
        tick(1);
        pop_out();

        // reset in the middle of REQUEST
        btn_in = 2'b01;
        wait_state(2'b01, 20, "t6_reach_req");
        tick(3);
        rst = 1'b1;
        exp_out("t6_rst", 1'b0, 2'b00, 1'b0, 8'd0, 2'b00);
        tick(1);
        pop_out();
        rst = 1'b0;

        // timeout and ped_green on the same edge: green wins, no error
        wait_state(2'b01, 20, "t7_reach_req");
        btn_in = 2'b00;
        tick(119);
        ped_green = 1'b1;
        exp_out("t7_race", 1'b0, 2'b00, 1'b0, 8'd0, 2'b10);
        tick(1);
        pop_out();
        ped_green = 1'b0;
        exp_out("t7_hold", 1'b0, 2'b00, 1'b0, 8'd1, 2'b11);
        tick(1);
        pop_out();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
